pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control_pkg.sv | 13 +
 rtl/pipeline_control_sat_counter.sv | 24 ++
 rtl/pipeline_control.sv | 140 ++++++++++++++
 tb/tb_pipeline_control.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the pipeline control block.
// Holds the control FSM state encoding and the default performance counter width.
package pipeline_control_pkg;

    localparam int unsigned CntWDefault = 16;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock, counts on rising edge
//   rst_n - asynchronous active-low reset, clears count
//   inc   - increment request for this cycle
//   count - current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// Five-stage pipeline hazard/stall/flush controller.
// Ports:
//   clk, rst_n                 - clock and asynchronous active-low reset
//   load_use_stall             - ID-stage load-use hazard
//   branch_taken               - redirect resolved in MEM (PC mux already on target)
//   mem_req, mem_ready         - MEM-stage access and its completion
//   halt_req                   - ecall/ebreak retiring in WB
//   pc_we, *_we                - PC and pipeline register write enables
//   *_flush, mem_wb_bubble     - insert NOPs into pipeline registers
//   halted                     - core stopped until reset
//   stall_cnt, flush_cnt       - saturating performance counters
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e state_q, state_d;
    logic   redirect_pend_q, redirect_pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StRun;
            redirect_pend_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        redirect_pend_d = redirect_pend_q;
        pc_we           = 1'b1;
        if_id_we        = 1'b1;
        id_ex_we        = 1'b1;
        ex_mem_we       = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        mem_wb_bubble   = 1'b0;
        halted          = 1'b0;

        unique case (state_q)
            StRun: begin
                if (halt_req) begin
                    {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
                    state_d = StHalt;
                end else if (mem_req && !mem_ready) begin
                    {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
                    mem_wb_bubble = 1'b1;
                    state_d       = StMemWait;
                    // The redirect must survive the memory stall and be applied on release.
                    if (branch_taken) redirect_pend_d = 1'b1;
                end else if (branch_taken) begin
                    {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
                end else if (load_use_stall) begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            StMemWait: begin
                // halt_req is ignored here: WB only ever sees a bubble while waiting.
                if (!mem_ready) begin
                    {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
                    mem_wb_bubble = 1'b1;
                    if (branch_taken) redirect_pend_d = 1'b1;
                end else begin
                    state_d         = StRun;
                    redirect_pend_d = 1'b0;
                    if (branch_taken || redirect_pend_q) begin
                        {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
                    end else if (load_use_stall) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            end
            StHalt: begin
                {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b0000;
                mem_wb_bubble = 1'b1;
                halted        = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        // Outputs are combinational, so force them quiet while reset is held.
        if (!rst_n) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we}   = 4'b0000;
            {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b000;
            mem_wb_bubble = 1'b0;
            halted        = 1'b0;
        end
    end

    logic stall_inc;
    assign stall_inc = !pc_we && (state_q != StHalt);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_use_stall = 1'b0;
    logic         branch_taken = 1'b0;
    logic         mem_req = 1'b0;
    logic         mem_ready = 1'b0;
    logic         halt_req = 1'b0;
    logic         pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic         if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble, halted;
    logic [W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // {pc,ifid,idex,exmem we | 3 flushes | bubble | halted | stall_cnt | flush_cnt}
    typedef logic [16:0] outv_t;
    outv_t sb_q[$];

    // Reference model state: 0 run, 1 mem wait, 2 halt
    int           m_state;
    logic         m_pend;
    logic [W-1:0] m_stall, m_flush;

    pipeline_control #(
        .CNT_W (W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .halt_req       (halt_req),
        .pc_we          (pc_we),
        .if_id_we       (if_id_we),
        .id_ex_we       (id_ex_we),
        .ex_mem_we      (ex_mem_we),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .mem_wb_bubble  (mem_wb_bubble),
        .halted         (halted),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic outv_t outs();
        return {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, ex_mem_flush,
                mem_wb_bubble, halted, stall_cnt, flush_cnt};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pend  = 1'b0;
        m_stall = '0;
        m_flush = '0;
    endtask

    // Push the outputs expected for this cycle, then advance the model by one edge.
    task automatic model_step(input logic lus, input logic br, input logic mreq,
                              input logic mrdy, input logic hr);
        logic [3:0] we;
        logic [2:0] fl;
        logic       bub, hlt;
        int         nstate;
        logic       npend;
        we = 4'b1111; fl = 3'b000; bub = 1'b0; hlt = 1'b0;
        nstate = m_state; npend = m_pend;
        if (m_state == 2) begin
            we = 4'b0000; bub = 1'b1; hlt = 1'b1;
        end else if (m_state == 0 && hr) begin
            we = 4'b0000; nstate = 2;
        end else if (!mrdy && (m_state == 1 || mreq)) begin
            we = 4'b0000; bub = 1'b1; nstate = 1;
            if (br) npend = 1'b1;
        end else begin
            if (m_state == 1) begin
                nstate = 0; npend = 1'b0;
            end
            if (br || (m_state == 1 && m_pend)) fl = 3'b111;
            else if (lus) begin
                we = 4'b0011; fl = 3'b010;
            end
        end
        sb_q.push_back({we, fl, bub, hlt, m_stall, m_flush});
        if (!we[3] && m_state != 2 && m_stall != 4'hf) m_stall = m_stall + 1'b1;
        if (fl[2] && m_flush != 4'hf) m_flush = m_flush + 1'b1;
        m_state = nstate;
        m_pend  = npend;
    endtask

    task automatic step(input logic lus, input logic br, input logic mreq,
                        input logic mrdy, input logic hr);
        @(posedge clk);
        #1;
        load_use_stall = lus;
        branch_taken   = br;
        mem_req        = mreq;
        mem_ready      = mrdy;
        halt_req       = hr;
        model_step(lus, br, mreq, mrdy, hr);
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle with busy inputs; outputs must drop at once.
    task automatic apply_reset(input string name);
        @(posedge clk);
        #2;
        {load_use_stall, branch_taken, mem_req, mem_ready, halt_req} = 5'b11111;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 17'h0) begin
            errors++;
            $display("FAIL %s reset outputs: got %h want %h", name, outs(), 17'h0);
        end
        @(negedge clk);
        @(negedge clk);
        {load_use_stall, branch_taken, mem_req, mem_ready, halt_req} = 5'b00000;
        rst_n = 1'b1;
        model_reset();
        sb_q.delete();
    endtask

    task automatic test_reset();
        outv_t exp;
        apply_reset("reset");
        step(0, 0, 0, 0, 0);
        exp = sb_q.pop_front();
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL reset_first_run: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_load_use();
        outv_t exp;
        apply_reset("load_use");
        for (int i = 0; i < 2; i++) begin
            step(i == 0, 0, 0, 0, 0);
            exp = sb_q.pop_front();
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL load_use cyc%0d: got %h want %h", i, outs(), exp);
            end
        end
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use stall_cnt: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_branch_over_stall();
        outv_t exp;
        apply_reset("branch");
        step(1, 1, 0, 0, 0);
        exp = sb_q.pop_front();
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL branch_over_stall: got %h want %h", outs(), exp);
        end
        checks++;
        if ({if_id_flush, id_ex_flush, ex_mem_flush, pc_we} !== 4'hf) begin
            errors++;
            $display("FAIL branch_flush_bits: got %b want 1111",
                     {if_id_flush, id_ex_flush, ex_mem_flush, pc_we});
        end
        step(0, 0, 0, 0, 0);
        exp = sb_q.pop_front();
        checks++;
        if ({outs(), flush_cnt, stall_cnt} !== {exp, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL branch_counters: got %h/%0d/%0d want %h/1/0",
                     outs(), flush_cnt, stall_cnt, exp);
        end
    endtask

    task automatic test_mem_wait();
        outv_t      exp;
        logic [4:0] tbl[5];
        // {lus, br, mreq, mrdy, hr}
        tbl = '{5'b00100, 5'b01100, 5'b00100, 5'b00110, 5'b00000};
        apply_reset("mem_wait");
        for (int i = 0; i < 5; i++) begin
            step(tbl[i][4], tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0]);
            exp = sb_q.pop_front();
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL mem_wait cyc%0d: got %h want %h", i, outs(), exp);
            end
            if (i < 3) begin
                checks++;
                if ({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_bubble} !== 5'b00001) begin
                    errors++;
                    $display("FAIL mem_wait_hold cyc%0d: got %b want 00001", i,
                             {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_bubble});
                end
            end
            if (i == 3) begin
                checks++;
                if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b111) begin
                    errors++;
                    $display("FAIL mem_wait_release_flush: got %b want 111",
                             {if_id_flush, id_ex_flush, ex_mem_flush});
                end
            end
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== {4'd3, 4'd1}) begin
            errors++;
            $display("FAIL mem_wait_counters: got %0d/%0d want 3/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_halt();
        outv_t exp;
        apply_reset("halt");
        step(0, 1, 0, 0, 1);
        exp = sb_q.pop_front();
        checks++;
        if (outs() !== exp) begin
            errors++;
            $display("FAIL halt_entry: got %h want %h", outs(), exp);
        end
        checks++;
        if ({pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, ex_mem_flush,
             halted} !== 8'h00) begin
            errors++;
            $display("FAIL halt_entry_bits: got %h want 00", outs());
        end
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            exp = sb_q.pop_front();
            checks++;
            if (outs() !== exp || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold cyc%0d: got %h want %h", i, outs(), exp);
            end
        end
    endtask

    task automatic test_saturation();
        outv_t exp;
        apply_reset("saturation");
        for (int i = 0; i < 21; i++) begin
            step(i < 20, 0, 0, 0, 0);
            exp = sb_q.pop_front();
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL saturation cyc%0d: got %h want %h", i, outs(), exp);
            end
        end
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL saturation_value: got %0d want 15", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        outv_t exp;
        apply_reset("mid_wait_pre");
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            exp = sb_q.pop_front();
            checks++;
            if (i == 1 && outs() !== exp) begin
                errors++;
                $display("FAIL mid_wait_setup: got %h want %h", outs(), exp);
            end
        end
        apply_reset("mid_wait");
        step(0, 0, 1, 1, 0);
        exp = sb_q.pop_front();
        checks++;
        if (outs() !== exp || if_id_flush !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait_no_redirect: got %h want %h", outs(), exp);
        end
        step(0, 0, 0, 0, 0);
        exp = sb_q.pop_front();
        checks++;
        if (outs() !== exp || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_wait_flush_cnt: got %h want %h", outs(), exp);
        end
    endtask

    task automatic test_back_to_back();
        outv_t exp;
        apply_reset("random");
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL random_sb_empty cyc%0d: got 0 entries want 1", i);
            end else begin
                exp = sb_q.pop_front();
                checks++;
                if (outs() !== exp) begin
                    errors++;
                    $display("FAIL random cyc%0d: got %h want %h", i, outs(), exp);
                end
            end
            if (halted && (i % 50 == 49)) apply_reset("random_rearm");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_branch_over_stall();
        test_mem_wait();
        test_halt();
        test_saturation();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
